// File: rtl/melody_sequencer.sv
// Multi-voice gate/pitch step sequencer with square oscillators and a sigma-delta PWM mixer.
// Define MELODY_SEQ_LEGATO_EN to drop the half-step articulation mask (full-step gates).
module melody_sequencer #(
    parameter int STEPS  = 16,
    parameter int VOICES = 2,
    parameter int DIV_W  = 20,
    localparam int SW = $clog2(STEPS),
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [VW-1:0]     rec_voice,
    input  logic              gate_set,
    input  logic              gate_clear,
    input  logic              pitch_wr,
    input  logic [3:0]        pitch_in,
    output logic [SW-1:0]     step,
    output logic              step_tick,
    output logic [VOICES-1:0] voice_gate,
    output logic              pwmout
);

    localparam int AW = $clog2(VOICES) + 2;

    logic [DIV_W-1:0]  r_presc;
    logic [SW-1:0]     r_step;
    logic              r_tick;
    logic [STEPS-1:0]  r_gate  [VOICES];
    logic [3:0]        r_pitch [VOICES][STEPS];
    logic [17:0]       r_phase [VOICES];
    logic [AW-1:0]     r_acc;
    logic              r_pwm;

    logic [17:0]       w_inc   [VOICES];
    logic [VOICES-1:0] w_vgate;
    logic [AW-1:0]     w_level;
    logic [AW-1:0]     w_sum;
    logic              w_art;
    logic              w_edit_ok;
    logic              w_pmax;

    function automatic logic [17:0] f_inc(input logic [3:0] p);
        logic [17:0] base;
        case (p[2:0])
            3'd0:    base = 18'd5715;
            3'd1:    base = 18'd6415;
            3'd2:    base = 18'd7201;
            3'd3:    base = 18'd7629;
            3'd4:    base = 18'd8563;
            3'd5:    base = 18'd9612;
            3'd6:    base = 18'd10789;
            default: base = 18'd11430;
        endcase
        return p[3] ? {base[16:0], 1'b0} : base;
    endfunction

`ifdef MELODY_SEQ_LEGATO_EN
    assign w_art = 1'b1;
`else
    assign w_art = ~r_presc[DIV_W-1];
`endif

    assign w_pmax    = &r_presc;
    assign w_edit_ok = 32'(rec_voice) < 32'(VOICES);

    always_comb begin
        w_level = '0;
        for (int v = 0; v < VOICES; v++) begin
            w_inc[v]   = f_inc(r_pitch[v][r_step]);
            w_vgate[v] = run & r_gate[v][r_step] & w_art;
            w_level    = w_level + AW'(w_vgate[v] & r_phase[v][17]);
        end
        w_sum = r_acc + w_level;
    end

    // Prescaler and step counter only move while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_step  <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (run) begin
                r_presc <= r_presc + DIV_W'(1);
                if (w_pmax) begin
                    r_tick <= 1'b1;
                    if (r_step == SW'(STEPS - 1))
                        r_step <= '0;
                    else
                        r_step <= r_step + SW'(1);
                end
            end
        end
    end

    // Edits target the step currently shown, so a max-cycle edit hits the outgoing step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                r_gate[v] <= '0;
                for (int s = 0; s < STEPS; s++)
                    r_pitch[v][s] <= '0;
            end
        end else if (w_edit_ok) begin
            if (gate_clear)
                r_gate[rec_voice][r_step] <= 1'b0;
            else if (gate_set)
                r_gate[rec_voice][r_step] <= 1'b1;
            if (pitch_wr)
                r_pitch[rec_voice][r_step] <= pitch_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++)
                r_phase[v] <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++)
                r_phase[v] <= r_phase[v] + w_inc[v];
        end
    end

    // First-order sigma-delta: density of ones tracks level/VOICES
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_pwm <= 1'b0;
        end else if (w_sum >= AW'(VOICES)) begin
            r_acc <= w_sum - AW'(VOICES);
            r_pwm <= 1'b1;
        end else begin
            r_acc <= w_sum;
            r_pwm <= 1'b0;
        end
    end

    assign step       = r_step;
    assign step_tick  = r_tick;
    assign voice_gate = w_vgate;
    assign pwmout     = r_pwm;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed and random stimulus against a behavioural model
// built from run-cycle counts, per-step pattern arrays and integer phase/accumulator math.
module tb_melody_sequencer;

    localparam int STEPS  = 5;
    localparam int VOICES = 3;
    localparam int DIV_W  = 4;
    localparam int SW     = $clog2(STEPS);
    localparam int VW     = 2;
    localparam int PER    = 1 << DIV_W;
    localparam int PMOD   = 1 << 18;
`ifdef MELODY_SEQ_LEGATO_EN
    localparam bit LEGATO = 1'b1;
`else
    localparam bit LEGATO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic [VW-1:0]     rec_voice = '0;
    logic              gate_set = 1'b0;
    logic              gate_clear = 1'b0;
    logic              pitch_wr = 1'b0;
    logic [3:0]        pitch_in = '0;
    logic [SW-1:0]     step;
    logic              step_tick;
    logic [VOICES-1:0] voice_gate;
    logic              pwmout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    melody_sequencer #(.STEPS(STEPS), .VOICES(VOICES), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .run(run), .rec_voice(rec_voice),
        .gate_set(gate_set), .gate_clear(gate_clear), .pitch_wr(pitch_wr),
        .pitch_in(pitch_in), .step(step), .step_tick(step_tick),
        .voice_gate(voice_gate), .pwmout(pwmout)
    );

    // Behavioural model: position derives from total run cycles since reset
    int runcnt, acc, m_pwm, m_tick;
    int phase [VOICES];
    int gate  [VOICES][STEPS];
    int pitch [VOICES][STEPS];
    int tune  [8] = '{5715, 6415, 7201, 7629, 8563, 9612, 10789, 11430};

    function automatic int m_step();
        return (runcnt / PER) % STEPS;
    endfunction

    function automatic int m_presc();
        return runcnt % PER;
    endfunction

    function automatic int m_vgate(int v);
        return (run && gate[v][m_step()] != 0 &&
                (LEGATO || m_presc() < PER / 2)) ? 1 : 0;
    endfunction

    function automatic int m_inc(int v);
        int p;
        p = pitch[v][m_step()];
        return tune[p % 8] * ((p >= 8) ? 2 : 1);
    endfunction

    task automatic model_reset();
        runcnt = 0; acc = 0; m_pwm = 0; m_tick = 0;
        for (int v = 0; v < VOICES; v++) begin
            phase[v] = 0;
            for (int s = 0; s < STEPS; s++) begin
                gate[v][s] = 0;
                pitch[v][s] = 0;
            end
        end
    endtask

    task automatic model_step();
        int lvl, s, rv;
        int nph [VOICES];
        s = m_step();
        lvl = 0;
        for (int v = 0; v < VOICES; v++) begin
            if (m_vgate(v) != 0 && phase[v] >= PMOD / 2) lvl++;
            nph[v] = (phase[v] + m_inc(v)) % PMOD;
        end
        for (int v = 0; v < VOICES; v++) phase[v] = nph[v];
        acc = acc + lvl;
        if (acc >= VOICES) begin
            m_pwm = 1; acc = acc - VOICES;
        end else begin
            m_pwm = 0;
        end
        rv = int'(rec_voice);
        if (rv < VOICES) begin
            if (gate_clear) gate[rv][s] = 0;
            else if (gate_set) gate[rv][s] = 1;
            if (pitch_wr) pitch[rv][s] = int'(pitch_in);
        end
        m_tick = (run && m_presc() == PER - 1) ? 1 : 0;
        if (run) runcnt++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [VOICES-1:0] eg;
        for (int v = 0; v < VOICES; v++) eg[v] = m_vgate(v) != 0;
        chk("step", 32'(step), 32'(m_step()));
        chk("step_tick", 32'(step_tick), 32'(m_tick));
        chk("voice_gate", 32'(voice_gate), 32'(eg));
        chk("pwmout", 32'(pwmout), 32'(m_pwm));
    endtask

    // Inputs are applied at the falling edge; model and checks follow the rising edge
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic run_n(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic edit(int v, bit s, bit c, bit w, int p);
        rec_voice = VW'(v); gate_set = s; gate_clear = c;
        pitch_wr = w; pitch_in = 4'(p);
        cyc();
        gate_set = 0; gate_clear = 0; pitch_wr = 0;
    endtask

    task automatic wait_presc(int target);
        int n;
        n = 0;
        while (m_presc() != target && n < 4 * PER) begin
            cyc();
            n++;
        end
        chk("wait_presc_bound", 32'(m_presc()), 32'(target));
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        rst = 1;
        run_n(2);
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_pwm", 32'(pwmout), 32'd0);
        rst = 0;
        run = 1;
        run_n(2 * PER * STEPS + 7);

        wait_presc(0);
        edit(0, 1, 0, 1, 5);
        run_n(3 * PER);

        edit(1, 1, 0, 0, 0);
        edit(1, 1, 1, 0, 0);
        chk("clear_wins", 32'(voice_gate[1]), 32'd0);
        run_n(PER);

        for (int s = 0; s < STEPS; s++) begin
            wait_presc(1);
            for (int v = 0; v < VOICES; v++) edit(v, 1, 0, 1, 15);
        end
        edit(3, 0, 1, 1, 2);
        run_n(3 * PER * STEPS);

        wait_presc(5);
        run = 0;
        run_n(7);
        chk("run_low_gate", 32'(voice_gate), 32'd0);
        run = 1;
        run_n(2 * PER);

        wait_presc(PER - 1);
        edit(1, 0, 1, 1, 3);
        run_n(2 * PER);

        for (int i = 0; i < 1500; i++) begin
            run = ($urandom_range(0, 9) != 0);
            rec_voice = VW'($urandom_range(0, 3));
            gate_set = ($urandom_range(0, 9) == 0);
            gate_clear = ($urandom_range(0, 9) == 0);
            pitch_wr = ($urandom_range(0, 9) == 0);
            pitch_in = 4'($urandom_range(0, 15));
            cyc();
        end
        gate_set = 0; gate_clear = 0; pitch_wr = 0;
        run = 1;
        run_n(PER + 3);

        rst = 1;
        cyc();
        rst = 0;
        chk("midreset_step", 32'(step), 32'd0);
        for (int i = 0; i < 200; i++) begin
            rec_voice = VW'($urandom_range(0, 2));
            gate_set = ($urandom_range(0, 3) == 0);
            pitch_wr = ($urandom_range(0, 3) == 0);
            pitch_in = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
